// File: rtl/i2c_target_bit_engine.sv
// rtl/i2c_target_bit_engine.sv - I2C target bit/byte engine on oversampled SCL/SDA
// Define I2C_GENERAL_CALL_EN to also ACK the general-call address (7'h00, write).
module i2c_target_bit_engine #(
  parameter logic [6:0] TARGET_ADDR = 7'h5A,
  parameter int         SYNC_LEN    = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_sda_drive_d,
  output logic       o_busy,
  output logic       o_underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT
  } state_t;

  state_t                r_state;
  logic [SYNC_LEN-1:0]   r_scl_sync;
  logic [SYNC_LEN-1:0]   r_sda_sync;
  logic                  r_scl_p;
  logic                  r_sda_p;
  logic [7:0]            r_shift;
  logic [2:0]            r_bitcnt;
  logic                  r_rw;
  logic [7:0]            r_rx_data;
  logic                  r_rx_valid;
  logic                  r_tx_ready;
  logic                  r_underrun;
  logic                  r_sda_drive;

  logic                  w_scl_s;
  logic                  w_sda_s;
  logic                  w_scl_rise;
  logic                  w_start;
  logic                  w_stop;
  logic [7:0]            w_shift_next;
  logic                  w_gc;
  logic                  w_addr_ack;
  logic [7:0]            w_load_data;

  assign w_scl_s      = r_scl_sync[SYNC_LEN-1];
  assign w_sda_s      = r_sda_sync[SYNC_LEN-1];
  assign w_scl_rise   = !r_scl_p & w_scl_s;
  // Both SCL samples high excludes a same-cycle SCL edge from START/STOP.
  assign w_start      = r_scl_p & w_scl_s & r_sda_p & !w_sda_s;
  assign w_stop       = r_scl_p & w_scl_s & !r_sda_p & w_sda_s;
  assign w_shift_next = {r_shift[6:0], w_sda_s};

`ifdef I2C_GENERAL_CALL_EN
  assign w_gc = (w_shift_next[7:1] == 7'h00) && !w_shift_next[0];
`else
  assign w_gc = 1'b0;
`endif
  assign w_addr_ack = (w_shift_next[7:1] == TARGET_ADDR) || w_gc;

  // An empty transmit slot returns all-ones so SDA stays released.
  assign w_load_data = i_tx_valid ? i_tx_data : 8'hFF;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_p    <= 1'b1;
      r_sda_p    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_LEN-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_LEN-2:0], i_sda};
      r_scl_p    <= w_scl_s;
      r_sda_p    <= w_sda_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_shift     <= 8'h00;
      r_bitcnt    <= 3'd0;
      r_rw        <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_underrun  <= 1'b0;
      r_sda_drive <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_underrun <= 1'b0;
      if (w_start) begin
        r_state     <= S_ADDR;
        r_bitcnt    <= 3'd0;
        r_sda_drive <= 1'b0;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_bitcnt    <= 3'd0;
        r_sda_drive <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          S_ADDR: begin
            r_shift  <= w_shift_next;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_rw <= w_shift_next[0];
              if (w_addr_ack) begin
                r_state     <= S_ADDR_ACK;
                r_sda_drive <= 1'b1;
              end else begin
                r_state     <= S_WAIT;
                r_sda_drive <= 1'b0;
              end
            end
          end
          S_ADDR_ACK, S_TX_ACK: begin
            if (r_state == S_ADDR_ACK && !r_rw) begin
              r_state     <= S_RX;
              r_sda_drive <= 1'b0;
            end else if (r_state == S_TX_ACK && w_sda_s) begin
              r_state     <= S_WAIT;
              r_sda_drive <= 1'b0;
            end else begin
              r_state     <= S_TX;
              r_shift     <= w_load_data;
              r_sda_drive <= ~w_load_data[7];
              r_tx_ready  <= i_tx_valid;
              r_underrun  <= !i_tx_valid;
            end
          end
          S_TX: begin
            r_shift  <= {r_shift[6:0], 1'b1};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state     <= S_TX_ACK;
              r_sda_drive <= 1'b0;
            end else begin
              r_sda_drive <= ~r_shift[6];
            end
          end
          S_RX: begin
            r_shift  <= w_shift_next;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_rx_data   <= w_shift_next;
              r_rx_valid  <= 1'b1;
              r_state     <= S_RX_ACK;
              r_sda_drive <= 1'b1;
            end
          end
          S_RX_ACK: begin
            r_state     <= S_RX;
            r_sda_drive <= 1'b0;
          end
          default: r_sda_drive <= 1'b0;
        endcase
      end
    end
  end

  assign o_tx_ready    = r_tx_ready;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_sda_drive_d = r_sda_drive;
  assign o_busy        = (r_state != S_IDLE);
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_i2c_target_bit_engine.sv
// tb/tb_i2c_target_bit_engine.sv - scoreboard bench for i2c_target_bit_engine
module tb_i2c_target_bit_engine;
  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       pad = 1'b0;
  logic       sda_bus;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, sda_drive_d, busy, underrun;
  logic [7:0] rx_data;

  int         n_checks = 0;
  int         n_fail = 0;
  logic       mon_on = 1'b0;
  logic [7:0] q_rx[$];
  logic [1:0] q_tx[$];
  logic       q_pad[$];

  i2c_target_bit_engine dut (
    .i_clk(clk), .i_reset(reset), .i_scl(scl), .i_sda(sda_bus),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_sda_drive_d(sda_drive_d),
    .o_busy(busy), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  // Downstream pad flop: captures the drive value on each SCL fall.
  always @(negedge scl or posedge reset)
    if (reset) pad <= 1'b0;
    else       pad <= sda_drive_d;

  assign sda_bus = m_sda & ~pad;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: output with empty scoreboard at %0t", name, $time);
  endtask

  always @(posedge scl) if (mon_on) begin
    if (q_pad.size() == 0) unexpected("pad");
    else check("pad", {7'd0, pad}, {7'd0, q_pad.pop_front()});
  end

  always @(negedge clk) if (mon_on && rx_valid) begin
    if (q_rx.size() == 0) unexpected("rx_data");
    else check("rx_data", rx_data, q_rx.pop_front());
  end

  always @(negedge clk) if (mon_on && (tx_ready || underrun)) begin
    if (q_tx.size() == 0) unexpected("tx_event");
    else check("tx_event", {6'd0, tx_ready, underrun}, {6'd0, q_tx.pop_front()});
  end

  task automatic bit_cycle(input logic b, input logic exp_pad);
    q_pad.push_back(exp_pad);
    m_sda = b;
    #Q; scl = 1'b1;
    #(2*Q); scl = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack);
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], 1'b0);
    bit_cycle(1'b1, exp_ack);
  endtask

  task automatic read_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) bit_cycle(1'b1, ~d[i]);
  endtask

  task automatic start_cond();
    m_sda = 1'b1;
    #Q;
    if (!scl) begin
      q_pad.push_back(1'b0);
      scl = 1'b1;
      #Q;
    end
    m_sda = 1'b0;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic stop_cond();
    m_sda = 1'b0;
    #Q;
    q_pad.push_back(1'b0);
    scl = 1'b1;
    #Q; m_sda = 1'b1;
    #(2*Q);
  endtask

  initial begin
    reset = 1'b1;
    #20;
    check("reset sda_drive_d", {7'd0, sda_drive_d}, 8'd0);
    check("reset busy", {7'd0, busy}, 8'd0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset pulses", {5'd0, rx_valid, tx_ready, underrun}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #Q;
    mon_on = 1'b1;

    // Write of 8'h3C to 0x5A.
    q_rx.push_back(8'h3C);
    start_cond();
    write_byte(8'hB4, 1'b1);
    write_byte(8'h3C, 1'b1);
    check("write busy", {7'd0, busy}, 8'd1);
    stop_cond();
    check("write busy after stop", {7'd0, busy}, 8'd0);

    // Read of 8'hA5 (ACK) then 8'h0F (NACK).
    tx_data = 8'hA5; tx_valid = 1'b1;
    q_tx.push_back(2'b10);
    q_tx.push_back(2'b10);
    start_cond();
    write_byte(8'hB5, 1'b1);
    read_byte(8'hA5);
    tx_data = 8'h0F;
    bit_cycle(1'b0, 1'b0);
    read_byte(8'h0F);
    bit_cycle(1'b1, 1'b0);
    check("read busy in wait", {7'd0, busy}, 8'd1);
    stop_cond();
    check("read busy after stop", {7'd0, busy}, 8'd0);

    // Address mismatch.
    start_cond();
    write_byte(8'h44, 1'b0);
    check("mismatch busy", {7'd0, busy}, 8'd1);
    stop_cond();
    check("mismatch busy after stop", {7'd0, busy}, 8'd0);

    // Underrun: no byte offered for the read.
    tx_valid = 1'b0;
    q_tx.push_back(2'b01);
    start_cond();
    write_byte(8'hB5, 1'b1);
    read_byte(8'hFF);
    bit_cycle(1'b1, 1'b0);
    stop_cond();

    // Repeated START after 4 bits of a data byte.
    q_rx.push_back(8'h81);
    start_cond();
    write_byte(8'hB4, 1'b1);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0);
    start_cond();
    write_byte(8'hB4, 1'b1);
    write_byte(8'h81, 1'b1);
    stop_cond();

    // Reset during the address ACK bit.
    start_cond();
    for (int i = 7; i >= 0; i--) bit_cycle(((8'hB4 >> i) & 8'h01) != 8'h00, 1'b0);
    q_pad.push_back(1'b1);
    m_sda = 1'b1;
    #Q; scl = 1'b1;
    #Q; reset = 1'b1;
    #1;
    check("reset mid-ack sda_drive_d", {7'd0, sda_drive_d}, 8'd0);
    check("reset mid-ack busy", {7'd0, busy}, 8'd0);
    #(Q-1); reset = 1'b0;
    #Q; scl = 1'b0;
    #Q;
    start_cond();
    write_byte(8'hB4, 1'b1);
    check("post-reset busy", {7'd0, busy}, 8'd1);
    stop_cond();

    // General-call address.
    start_cond();
`ifdef I2C_GENERAL_CALL_EN
    write_byte(8'h00, 1'b1);
`else
    write_byte(8'h00, 1'b0);
`endif
    stop_cond();
    check("gc busy after stop", {7'd0, busy}, 8'd0);

    #(4*Q);
    check("pad queue drained", q_pad.size()[7:0], 8'd0);
    check("rx queue drained", q_rx.size()[7:0], 8'd0);
    check("tx queue drained", q_tx.size()[7:0], 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
